pwm_multichannel: RTL and testbench
===================================

# pwm_multichannel

Multi-channel PWM generator for the AM transmit path, the parametrised successor to the single-channel PWM block. It drives N_CH PWM outputs from a shared step timebase. Per-channel duty values arrive as one vector through a valid/ready handshake and are double-buffered, so they only take effect at a period boundary. Left- or center-aligned modes, duty saturation, a divided symbol tick and an underrun flag are added for the modulator that feeds it.

## Interface
- N_CH, 2: number of PWM channels
- PWM_STEPS, 64: steps per PWM period (≥2)
- DUTY_W, $clog2(PWM_STEPS+1): duty width per channel
- CLKS_PER_STEP, 4: clk cycles per step (≥1)
- SYMB_DIV, 1000: PWM periods per symbol tick (≥1)
- INVERT, 0: 1 = outputs active-low; idle level = INVERT

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  timebase run; low = hold counters, outputs at idle level
- center  in  1  0 = left-aligned, 1 = center-aligned; sampled at period boundary
- duty_data  in  N_CH*DUTY_W  channel i at bits [i*DUTY_W +: DUTY_W]
- duty_valid  in  1  duty vector valid
- duty_ready  out  1  shadow buffer free
- pwm  out  N_CH  PWM outputs, registered
- symbol  out  1  one-cycle pulse every SYMB_DIV periods
- period_start  out  1  one-cycle pulse at each period boundary
- underrun  out  1  one-cycle pulse at a boundary with no pending duty

## Operation
- Prescaler: counts 0..CLKS_PER_STEP-1 while enable=1, wraps. step_tick = enable && prescaler==CLKS_PER_STEP-1.
- Step counter: 0..PWM_STEPS-1, advances on step_tick, wraps to 0.
- Boundary: step_tick && step==PWM_STEPS-1.
- Period counter: 0..SYMB_DIV-1, advances on boundary. symbol pulses on the boundary where it equals SYMB_DIV-1.
- Handshake: duty_ready = !pending. Accept = duty_valid && duty_ready. On accept the shadow captures duty_data and pending is set.
- Commit: at a boundary with pending=1, active copies shadow, mode_reg copies center, and pending clears. With pending=0, active is held and underrun pulses; mode_reg still samples center.
- Accept and boundary in the same cycle (only possible when pending=0): the boundary sees no pending data, so underrun pulses. The new vector is stored in the shadow and commits at the next boundary.
- Saturation: duty d > PWM_STEPS is treated as PWM_STEPS at commit.
- Left-aligned: channel active when step < d.
- Center-aligned: lo = (PWM_STEPS-d)>>1; channel active when lo ≤ step < lo+d.
- d=0 gives always idle; d=PWM_STEPS gives always active.
- Output level = active XOR INVERT. With enable=0, all pwm go to the idle level and counters hold. The handshake and shadow still operate; no commit happens.

## Timing
- Reset (rst low, async): prescaler, step, period counter, active, shadow, pending and mode_reg all clear.
- Reset values: pwm = {N_CH{INVERT}}; symbol, period_start, underrun = 0; duty_ready = 1 (pending=0).
- Reset mid-period: outputs go idle immediately. After release, the first step_tick occurs CLKS_PER_STEP cycles later.
- pwm[i] at cycle t+1 reflects step, active and mode_reg at cycle t (1-cycle latency).
- A new active value affects pwm from the first cycle of step 0, i.e. 1 cycle after the boundary cycle.
- period_start, symbol and underrun are registered and assert in the cycle after the boundary cycle, coincident with step 0 output.
- Period = PWM_STEPS*CLKS_PER_STEP clk cycles.
- Duty-cycle resolution: d*CLKS_PER_STEP active cycles per period.

## Test plan
- N_CH=2, PWM_STEPS=64, CLKS_PER_STEP=4, left mode; load {ch1=32, ch0=16}. -> After commit, pwm0 is high 64 of 256 cycles starting at step 0, and pwm1 is high 128 of 256 cycles. period_start pulses every 256 cycles.
- center=1, d=16. -> pwm high for steps 24..39 (cycles 96..159 of the period). center=1, d=15 -> high for steps 24..38.
- d=0 on ch0 and d=100 on ch1. -> pwm0 constantly low; pwm1 constantly high (saturated to 64). With INVERT=1, both are the complement.
- Single vector load, then no further valid. -> underrun pulses at every subsequent boundary and duty is held. SYMB_DIV=4 -> symbol pulses once per 4 period_start pulses.
- Two vectors presented back-to-back with duty_valid held high. -> First is accepted and duty_ready drops. Second stalls until the cycle after the next boundary, then is accepted; each vector commits at successive boundaries. Same-cycle accept and boundary -> underrun=1 and commit at the following boundary.
- rst asserted mid-period, and enable low for 100 cycles. -> On reset, pwm goes idle asynchronously and duty_ready=1. With enable low, pwm stays idle, step holds its value, and the period resumes from that step after enable returns high.

Source files
------------

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator with a shared step timebase and double-buffered duty vectors.
// Duty vectors are accepted through valid/ready and take effect only at a period boundary.
module pwm_multichannel #(
    parameter int N_CH          = 2,
    parameter int PWM_STEPS     = 64,
    parameter int DUTY_W        = $clog2(PWM_STEPS + 1),
    parameter int CLKS_PER_STEP = 4,
    parameter int SYMB_DIV      = 1000,
    parameter int INVERT        = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     center,
    input  logic [N_CH*DUTY_W-1:0]   duty_data,
    input  logic                     duty_valid,
    output logic                     duty_ready,
    output logic [N_CH-1:0]          pwm,
    output logic                     symbol,
    output logic                     period_start,
    output logic                     underrun
);

    localparam int PS_W = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
    localparam int ST_W = $clog2(PWM_STEPS);
    localparam int PC_W = (SYMB_DIV > 1) ? $clog2(SYMB_DIV) : 1;
    localparam int CW   = DUTY_W + 1;

    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PWM_STEPS);
    localparam logic [CW-1:0]     STEPS_C  = CW'(PWM_STEPS);
    localparam logic              IDLE     = (INVERT != 0);

    logic [PS_W-1:0]        presc_q, presc_d;
    logic [ST_W-1:0]        step_q, step_d;
    logic [PC_W-1:0]        per_q, per_d;
    logic [N_CH*DUTY_W-1:0] active_q, active_d;
    logic [N_CH*DUTY_W-1:0] shadow_q, shadow_d;
    logic                   pending_q, pending_d;
    logic                   mode_q, mode_d;
    logic [N_CH-1:0]        pwm_q, pwm_d;
    logic                   symbol_q, symbol_d;
    logic                   period_start_q, period_start_d;
    logic                   underrun_q, underrun_d;

    logic step_tick;
    logic boundary;
    logic accept;

    function automatic logic [DUTY_W-1:0] saturate(input logic [DUTY_W-1:0] d);
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction

    function automatic logic chan_on(input logic [ST_W-1:0] step,
                                     input logic [DUTY_W-1:0] d,
                                     input logic ctr);
        logic [CW-1:0] s;
        logic [CW-1:0] dw;
        logic [CW-1:0] lo;
        s  = CW'(step);
        dw = CW'(d);
        lo = (STEPS_C - dw) >> 1;
        if (ctr) begin
            return (s >= lo) && (s < lo + dw);
        end
        return s < dw;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        presc_d        = presc_q;
        step_d         = step_q;
        per_d          = per_q;
        active_d       = active_q;
        shadow_d       = shadow_q;
        pending_d      = pending_q;
        mode_d         = mode_q;
        pwm_d          = {N_CH{IDLE}};

        step_tick = enable && (presc_q == PS_W'(CLKS_PER_STEP - 1));
        boundary  = step_tick && (step_q == ST_W'(PWM_STEPS - 1));
        accept    = duty_valid && !pending_q;

        if (enable) begin
            presc_d = step_tick ? '0 : presc_q + PS_W'(1);
        end
        if (step_tick) begin
            step_d = (step_q == ST_W'(PWM_STEPS - 1)) ? '0 : step_q + ST_W'(1);
        end

        if (boundary) begin
            per_d     = (per_q == PC_W'(SYMB_DIV - 1)) ? '0 : per_q + PC_W'(1);
            mode_d    = center;
            pending_d = 1'b0;
            if (pending_q) begin
                for (int i = 0; i < N_CH; i++) begin
                    active_d[i*DUTY_W +: DUTY_W] = saturate(shadow_q[i*DUTY_W +: DUTY_W]);
                end
            end
        end

        // A vector accepted on a boundary cycle stays pending for the following boundary.
        if (accept) begin
            shadow_d  = duty_data;
            pending_d = 1'b1;
        end

        // NOTE: pwm is decoded from next-state values so the registered output lines up with
        // step_q and period_start (step 0 output appears in the cycle after the boundary).
        if (enable) begin
            for (int i = 0; i < N_CH; i++) begin
                pwm_d[i] = chan_on(step_d, active_d[i*DUTY_W +: DUTY_W], mode_d) ^ IDLE;
            end
        end

        period_start_d = boundary;
        symbol_d       = boundary && (per_q == PC_W'(SYMB_DIV - 1));
        underrun_d     = boundary && !pending_q;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q        <= '0;
            step_q         <= '0;
            per_q          <= '0;
            active_q       <= '0;
            shadow_q       <= '0;
            pending_q      <= 1'b0;
            mode_q         <= 1'b0;
            pwm_q          <= {N_CH{IDLE}};
            symbol_q       <= 1'b0;
            period_start_q <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            step_q         <= step_d;
            per_q          <= per_d;
            active_q       <= active_d;
            shadow_q       <= shadow_d;
            pending_q      <= pending_d;
            mode_q         <= mode_d;
            pwm_q          <= pwm_d;
            symbol_q       <= symbol_d;
            period_start_q <= period_start_d;
            underrun_q     <= underrun_d;
        end
    end

    assign duty_ready   = !pending_q;
    assign pwm          = pwm_q;
    assign symbol       = symbol_q;
    assign period_start = period_start_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: 2 channels, 64 steps, 4 clocks/step, symbol every 4 periods.
// A second instance with inverted outputs shares all inputs.
module tb_pwm_multichannel;

    localparam int N_CH   = 2;
    localparam int DUTY_W = 7;

    logic                   clk;
    logic                   rst;
    logic                   enable;
    logic                   center;
    logic [N_CH*DUTY_W-1:0] duty_data;
    logic                   duty_valid;
    logic                   duty_ready, duty_ready_i;
    logic [N_CH-1:0]        pwm, pwm_i;
    logic                   symbol, symbol_i;
    logic                   period_start, period_start_i;
    logic                   underrun, underrun_i;

    int total = 0;
    int bad   = 0;

    int cnt0, cnt1, icnt0, icnt1;
    int first0, last0, first1, last1;
    int ps_cnt, sym_cnt, ur_cnt, sym_stray;
    int n;

    pwm_multichannel #(
        .N_CH(N_CH), .PWM_STEPS(64), .DUTY_W(DUTY_W), .CLKS_PER_STEP(4), .SYMB_DIV(4), .INVERT(0)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .center(center),
        .duty_data(duty_data), .duty_valid(duty_valid), .duty_ready(duty_ready),
        .pwm(pwm), .symbol(symbol), .period_start(period_start), .underrun(underrun)
    );

    pwm_multichannel #(
        .N_CH(N_CH), .PWM_STEPS(64), .DUTY_W(DUTY_W), .CLKS_PER_STEP(4), .SYMB_DIV(4), .INVERT(1)
    ) u_inv (
        .clk(clk), .rst(rst), .enable(enable), .center(center),
        .duty_data(duty_data), .duty_valid(duty_valid), .duty_ready(duty_ready_i),
        .pwm(pwm_i), .symbol(symbol_i), .period_start(period_start_i), .underrun(underrun_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [N_CH*DUTY_W-1:0] mk(input int c1, input int c0);
        return {DUTY_W'(c1), DUTY_W'(c0)};
    endfunction

    // Advance to the next negedge where period_start is high; cycles taken returned in cnt.
    task automatic wait_ps(input string tag, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!period_start && cnt < 3000);
        check(tag, period_start, 1);
    endtask

    task automatic send(input logic [N_CH*DUTY_W-1:0] vec);
        int k;
        duty_data  = vec;
        duty_valid = 1'b1;
        k = 0;
        while (!duty_ready && k < 600) begin
            @(negedge clk);
            k++;
        end
        check("send_ready", duty_ready, 1);
        @(negedge clk);
        duty_valid = 1'b0;
    endtask

    // Sample n cycles starting at the current negedge (index 0).
    task automatic measure(input int cycles);
        cnt0 = 0; cnt1 = 0; icnt0 = 0; icnt1 = 0;
        first0 = -1; last0 = -1; first1 = -1; last1 = -1;
        ps_cnt = 0; sym_cnt = 0; ur_cnt = 0; sym_stray = 0;
        for (int i = 0; i < cycles; i++) begin
            if (pwm[0]) begin cnt0++; if (first0 < 0) first0 = i; last0 = i; end
            if (pwm[1]) begin cnt1++; if (first1 < 0) first1 = i; last1 = i; end
            if (pwm_i[0]) icnt0++;
            if (pwm_i[1]) icnt1++;
            if (period_start) ps_cnt++;
            if (symbol) sym_cnt++;
            if (underrun) ur_cnt++;
            if (symbol && !period_start) sym_stray++;
            @(negedge clk);
        end
    endtask

    initial begin
        int stray;
        rst        = 1'b1;
        enable     = 1'b0;
        center     = 1'b0;
        duty_data  = '0;
        duty_valid = 1'b0;
        #3 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_pwm", pwm, 0);
        check("rst_pwm_inv", pwm_i, 3);
        check("rst_ready", duty_ready, 1);
        check("rst_flags", {symbol, period_start, underrun}, 0);

        rst    = 1'b1;
        enable = 1'b1;

        // Left-aligned {ch1=32, ch0=16}
        send(mk(32, 16));
        wait_ps("a_commit_ps", n);
        check("a_commit_ur", underrun, 0);
        measure(256);
        check("a_cnt0", cnt0, 64);
        check("a_first0", first0, 0);
        check("a_last0", last0, 63);
        check("a_cnt1", cnt1, 128);
        check("a_ps_in_period", ps_cnt, 1);
        check("a_next_ps", period_start, 1);
        check("a_next_ur", underrun, 1);

        // Held duty, underrun every boundary, symbol every 4 periods
        measure(2048);
        check("sym_ps_cnt", ps_cnt, 8);
        check("sym_cnt", sym_cnt, 2);
        check("sym_stray", sym_stray, 0);
        check("ur_cnt", ur_cnt, 8);
        check("held_cnt0", cnt0, 512);

        // Center-aligned {ch1=15, ch0=16}
        center = 1'b1;
        send(mk(15, 16));
        wait_ps("c_commit_ps", n);
        measure(256);
        check("c_first0", first0, 96);
        check("c_last0", last0, 159);
        check("c_cnt0", cnt0, 64);
        check("c_first1", first1, 96);
        check("c_last1", last1, 155);
        check("c_cnt1", cnt1, 60);

        // Extremes: ch0=0, ch1=100 (saturates), plus inverted instance
        center = 1'b0;
        send(mk(100, 0));
        wait_ps("x_commit_ps", n);
        measure(256);
        check("x_cnt0", cnt0, 0);
        check("x_cnt1", cnt1, 256);
        check("x_inv_cnt0", icnt0, 256);
        check("x_inv_cnt1", icnt1, 0);

        // Back-to-back vectors with duty_valid held high
        wait_ps("b_align_ps", n);
        duty_data  = mk(8, 4);
        duty_valid = 1'b1;
        @(negedge clk);
        check("b_ready_drop", duty_ready, 0);
        duty_data = mk(20, 40);
        n = 0;
        while (!duty_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("b_stall_cycles", n, 255);
        check("b_ps_at_ready", period_start, 1);
        check("b_first_commit", pwm, 3);
        @(negedge clk);
        duty_valid = 1'b0;
        check("b_second_taken", duty_ready, 0);
        repeat (15) @(negedge clk);
        check("b_step4_pwm", pwm, 2);
        wait_ps("b_commit2_ps", n);
        check("b_commit2_ur", underrun, 0);
        measure(255);
        check("b_cnt0", cnt0, 160);
        check("b_cnt1", cnt1, 80);

        // Accept in the boundary cycle: underrun now, commit one period later
        duty_data  = mk(0, 0);
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        check("s_ps", period_start, 1);
        check("s_ur", underrun, 1);
        check("s_pending", duty_ready, 0);
        check("s_old_held", pwm, 3);
        wait_ps("s_commit_ps", n);
        check("s_commit_ur", underrun, 0);
        check("s_commit_pwm", pwm, 0);

        // Asynchronous reset mid-period
        send(mk(10, 10));
        wait_ps("r_commit_ps", n);
        repeat (10) @(negedge clk);
        duty_data  = mk(5, 5);
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        check("r_pending", duty_ready, 0);
        check("r_pwm_before", pwm, 3);
        #2 rst = 1'b0;
        #1;
        check("r_pwm_async", pwm, 0);
        check("r_pwm_inv_async", pwm_i, 3);
        check("r_ready_async", duty_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        wait_ps("r_first_ps", n);
        check("r_first_period", n, 256);
        check("r_ur_after", underrun, 1);

        // enable low for 100 cycles mid-period
        send(mk(32, 32));
        wait_ps("e_commit_ps", n);
        repeat (20) @(negedge clk);
        check("e_pwm_before", pwm, 3);
        enable = 1'b0;
        stray = 0;
        repeat (100) begin
            @(negedge clk);
            if (pwm != 2'b00 || period_start) stray++;
        end
        check("e_idle_hold", stray, 0);
        enable = 1'b1;
        @(negedge clk);
        check("e_resume_pwm", pwm, 3);
        wait_ps("e_resume_ps", n);
        check("e_remaining", n, 235);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
